// File: rtl/mic1_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mic1_pkg
// Brief   : Shared MIC-1 control-path constants (MIR field layout, widths).
// Revision: 1.0
// ============================================================================
package mic1_pkg;

    localparam int MPC_W        = 9;
    localparam int MBR_W        = 8;

    // Absolute bit positions of the control-flow fields in the 36-bit MIR
    localparam int NEXT_ADDR_HI = 35;
    localparam int NEXT_ADDR_LO = 27;
    localparam int JMPC_BIT     = 26;
    localparam int JAMN_BIT     = 25;
    localparam int JAMZ_BIT     = 24;

    localparam int MIR_LO       = JAMZ_BIT;
    localparam int MIR_W        = NEXT_ADDR_HI - MIR_LO + 1;

    localparam logic [MPC_W-1:0] RESET_ADDR = 9'h000;

endpackage

`default_nettype wire

// File: rtl/mic1_next_addr.sv
`default_nettype none
// ============================================================================
// Module  : mic1_next_addr
// Brief   : Combinational next-MPC logic (JAM high bit, JMPC MBR merge).
// Revision: 1.0
// ============================================================================
module mic1_next_addr
    import mic1_pkg::*;
(
    input  logic [MPC_W-1:0] i_next_addr,
    input  logic             i_jmpc,
    input  logic             i_jamn,
    input  logic             i_jamz,
    input  logic             i_n_s,
    input  logic             i_z_s,
    input  logic [MBR_W-1:0] i_mbr,
    output logic [MPC_W-1:0] o_next_mpc
);

    logic             w_high_bit;
    logic [MBR_W-1:0] w_low;

    assign w_high_bit = (i_jamz & i_z_s) | (i_jamn & i_n_s) | i_next_addr[MPC_W-1];

    // Multiway branch is an OR into the low byte, so it can never carry into bit 8
    assign w_low      = i_jmpc ? (i_next_addr[MBR_W-1:0] | i_mbr) : i_next_addr[MBR_W-1:0];

    assign o_next_mpc = {w_high_bit, w_low};

endmodule

`default_nettype wire

// File: rtl/mic1_mpc_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : mic1_mpc_sequencer
// Brief   : MIC-1 microsequencer: latches N/Z and registers the next MPC.
// Revision: 1.0
// ============================================================================
module mic1_mpc_sequencer
    import mic1_pkg::MPC_W, mic1_pkg::MBR_W, mic1_pkg::MIR_W, mic1_pkg::MIR_LO,
           mic1_pkg::NEXT_ADDR_HI, mic1_pkg::NEXT_ADDR_LO, mic1_pkg::JMPC_BIT,
           mic1_pkg::JAMN_BIT, mic1_pkg::JAMZ_BIT;
#(
    parameter int                ADDR_W     = MPC_W,
    parameter logic [ADDR_W-1:0] RESET_ADDR = mic1_pkg::RESET_ADDR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              N,
    input  logic              Z,
    input  logic [MBR_W-1:0]  MBR,
    input  logic [MIR_W-1:0]  MIR,
    output logic [ADDR_W-1:0] MPC
);

    logic              r_n_s;
    logic              r_z_s;
    logic [ADDR_W-1:0] r_mpc;
    logic [ADDR_W-1:0] w_next_mpc;

    // MIR port carries bits [35:24] only, so field positions are rebased
    mic1_next_addr u_next_addr (
        .i_next_addr (MIR[NEXT_ADDR_HI-MIR_LO:NEXT_ADDR_LO-MIR_LO]),
        .i_jmpc      (MIR[JMPC_BIT-MIR_LO]),
        .i_jamn      (MIR[JAMN_BIT-MIR_LO]),
        .i_jamz      (MIR[JAMZ_BIT-MIR_LO]),
        .i_n_s       (r_n_s),
        .i_z_s       (r_z_s),
        .i_mbr       (MBR),
        .o_next_mpc  (w_next_mpc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mpc <= RESET_ADDR;
            r_n_s <= 1'b0;
            r_z_s <= 1'b0;
        end else begin
            r_mpc <= w_next_mpc;
            r_n_s <= N;
            r_z_s <= Z;
        end
    end

    assign MPC = r_mpc;

endmodule

`default_nettype wire

// File: tb/tb_mic1_mpc_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_mic1_mpc_sequencer
// Brief   : Directed self-checking bench for the MIC-1 microsequencer.
// Revision: 1.0
// ============================================================================
module tb_mic1_mpc_sequencer;

    logic        clk;
    logic        rst;
    logic        N;
    logic        Z;
    logic [7:0]  MBR;
    logic [11:0] MIR;
    logic [8:0]  MPC;

    int          n_cmp;
    int          n_fail;
    logic [8:0]  exp_q[$];
    string       tag_q[$];

    mic1_mpc_sequencer dut (
        .clk (clk),
        .rst (rst),
        .N   (N),
        .Z   (Z),
        .MBR (MBR),
        .MIR (MIR),
        .MPC (MPC)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of stimulus, queue its expected MPC, then check after the edge
    task automatic step(input string tag, input logic r, input logic n, input logic z,
                        input logic [7:0] mbr, input logic [8:0] na, input logic jmpc,
                        input logic jamn, input logic jamz, input logic [8:0] exp_mpc);
        logic [8:0] e;
        string      t;
        rst = r;
        N   = n;
        Z   = z;
        MBR = mbr;
        MIR = {na, jmpc, jamn, jamz};
        exp_q.push_back(exp_mpc);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        n_cmp++;
        assert (MPC === e)
        else begin
            n_fail++;
            $error("FAIL %s: MPC observed %h expected %h", t, MPC, e);
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst = 1'b1; N = 1'b0; Z = 1'b0; MBR = 8'h00; MIR = 12'h000;

        // Reset with arbitrary MIR and flags: MPC stays at 0
        step("rst_e1",        1, 1, 1, 8'hFF, 9'h1FF, 1, 1, 1, 9'h000);
        step("rst_e2",        1, 1, 1, 8'hFF, 9'h1FF, 1, 1, 1, 9'h000);
        // Plain jump
        step("plain_e1",      0, 0, 0, 8'h00, 9'h1FF, 0, 0, 0, 9'h1FF);
        step("plain_e2",      0, 0, 0, 8'h00, 9'h1FF, 0, 0, 0, 9'h1FF);
        // JAMN: flag takes effect one edge after it is latched
        step("jamn_e1",       0, 1, 0, 8'h00, 9'h000, 1, 1, 0, 9'h000);
        step("jamn_e2",       0, 1, 0, 8'h00, 9'h000, 1, 1, 0, 9'h100);
        // JAMZ taken and not taken
        step("jamz_e1",       0, 0, 1, 8'h00, 9'h042, 0, 0, 1, 9'h042);
        step("jamz_e2",       0, 0, 1, 8'h00, 9'h042, 0, 0, 1, 9'h142);
        step("jamz_off",      0, 0, 1, 8'h00, 9'h042, 0, 0, 0, 9'h042);
        // Flags set but JAM bits clear: no effect
        step("noflag_e1",     0, 1, 1, 8'h00, 9'h033, 0, 0, 0, 9'h033);
        step("noflag_e2",     0, 1, 1, 8'h00, 9'h033, 0, 0, 0, 9'h033);
        // JAMN|JAMZ together; latched flags outlive the live inputs by one edge
        step("both_set",      0, 1, 1, 8'h00, 9'h005, 0, 1, 1, 9'h105);
        step("both_latched",  0, 0, 0, 8'h00, 9'h005, 0, 1, 1, 9'h105);
        step("both_clear",    0, 0, 0, 8'h00, 9'h005, 0, 1, 1, 9'h005);
        // NEXT_ADDRESS[8] forces the high bit with flags clear
        step("na8_force",     0, 0, 0, 8'h00, 9'h1A0, 0, 1, 1, 9'h1A0);
        // Multiway branch: OR, not add
        step("mw_59",         0, 0, 0, 8'h59, 9'h000, 1, 0, 0, 9'h059);
        step("mw_hi_kept",    0, 0, 0, 8'h10, 9'h101, 1, 0, 0, 9'h111);
        step("mw_merge",      0, 0, 0, 8'h0F, 9'h0F0, 1, 0, 0, 9'h0FF);
        step("mw_nocarry",    0, 0, 0, 8'h01, 9'h0FF, 1, 0, 0, 9'h0FF);
        step("mbr_ign",       0, 0, 0, 8'hAA, 9'h011, 0, 0, 0, 9'h011);
        // JMPC combined with JAMZ
        step("jz_prep",       0, 0, 1, 8'h00, 9'h000, 0, 0, 0, 9'h000);
        step("jmpc_jamz",     0, 0, 0, 8'h03, 9'h010, 1, 0, 1, 9'h113);
        // Reset mid-branch clears the pending N_s
        step("mid_pend",      0, 1, 0, 8'h00, 9'h000, 0, 1, 0, 9'h000);
        step("mid_rst",       1, 1, 1, 8'hFF, 9'h1FF, 1, 1, 1, 9'h000);
        step("mid_after",     0, 0, 0, 8'h00, 9'h000, 0, 1, 0, 9'h000);
        // Held reset from a non-zero MPC
        step("hold_prep",     0, 0, 0, 8'h00, 9'h1FF, 0, 0, 0, 9'h1FF);
        step("hold_r1",       1, 1, 1, 8'h00, 9'h1FF, 0, 0, 0, 9'h000);
        step("hold_r2",       1, 1, 1, 8'h00, 9'h1FF, 0, 0, 0, 9'h000);
        step("hold_r3",       1, 1, 1, 8'h00, 9'h1FF, 0, 0, 0, 9'h000);
        // Flags driven high during reset must not be latched
        step("rst_flags_clr", 0, 0, 0, 8'h00, 9'h000, 0, 1, 1, 9'h000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
